instbuffer_multi: RTL

Parametrised multi-lane instruction buffer between the icache/BPU fetch stage and the decode stage (if_id). It accepts up to FETCH_WIDTH fetched instructions per cycle, compacts the valid lanes in order into a single circular queue, and presents up to ISSUE_WIDTH oldest entries to decode. Decode consumes them in program order with a variable pop count. It replaces the fixed two-bank, one-FIFO-per-lane buffer: lanes no longer have to be popped in lockstep, and per-lane branch-prediction and exception metadata travel with each entry.

---
 rtl/instbuffer_multi.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/instbuffer_multi.sv
// instbuffer_multi: multi-lane in-order instruction queue between fetch (icache/BPU) and decode.
// Define INSTBUFFER_BYPASS_EN to forward an incoming fetch group straight to decode when the queue is empty.
module instbuffer_multi #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               stall,
    input  logic [FETCH_WIDTH-1:0]             in_valid,
    input  logic [FETCH_WIDTH*32-1:0]          in_pc,
    input  logic [FETCH_WIDTH*32-1:0]          in_inst,
    input  logic [FETCH_WIDTH-1:0]             in_is_branch,
    input  logic [FETCH_WIDTH-1:0]             in_pre_taken,
    input  logic [FETCH_WIDTH*32-1:0]          in_pre_branch_addr,
    input  logic [FETCH_WIDTH*6-1:0]           in_is_exception,
    input  logic [FETCH_WIDTH*7-1:0]           in_exception_cause,
    output logic                               in_ready,
    output logic [ISSUE_WIDTH-1:0]             out_valid,
    output logic [ISSUE_WIDTH*32-1:0]          out_pc,
    output logic [ISSUE_WIDTH*32-1:0]          out_inst,
    output logic [ISSUE_WIDTH-1:0]             out_is_branch,
    output logic [ISSUE_WIDTH-1:0]             out_pre_taken,
    output logic [ISSUE_WIDTH*32-1:0]          out_pre_branch_addr,
    output logic [ISSUE_WIDTH*6-1:0]           out_is_exception,
    output logic [ISSUE_WIDTH*7-1:0]           out_exception_cause,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   pop_count,
    output logic [$clog2(DEPTH+1)-1:0]         count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = 111;

    // Entry layout: {pc[110:79], inst[78:47], is_branch[46], pre_taken[45],
    //                pre_branch_addr[44:13], is_exception[12:7], exception_cause[6:0]}
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] head_reg, tail_reg;
    logic [CW-1:0] count_reg;

    logic [EW-1:0] lane_entry [FETCH_WIDTH];
    logic [CW-1:0] lane_idx   [FETCH_WIDTH];
    logic          lane_wr    [FETCH_WIDTH];
    logic [AW-1:0] lane_addr  [FETCH_WIDTH];
    logic [EW-1:0] rd_entry   [ISSUE_WIDTH];

    logic [CW-1:0] n_valid, n_push, n_pop, avail, wr_skip;
    logic          push_ok, bypass;

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
            assign lane_entry[gi] = {in_pc[gi*32 +: 32], in_inst[gi*32 +: 32],
                                     in_is_branch[gi], in_pre_taken[gi],
                                     in_pre_branch_addr[gi*32 +: 32],
                                     in_is_exception[gi*6 +: 6],
                                     in_exception_cause[gi*7 +: 7]};
        end
    endgenerate

    // Each valid lane's compacted slot is the number of valid lanes below it.
    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_idx[i] = acc;
            acc = acc + CW'(in_valid[i]);
        end
        n_valid = acc;
    end

    assign in_ready = (CW'(DEPTH) - count_reg) >= CW'(FETCH_WIDTH);
    assign push_ok  = in_ready && !flush && (|in_valid);
    assign n_push   = push_ok ? n_valid : '0;

`ifdef INSTBUFFER_BYPASS_EN
    assign bypass = (count_reg == '0) && !flush;
`else
    assign bypass = 1'b0;
`endif

    // In bypass the pop draws from the incoming group instead of storage.
    assign avail = bypass ? n_push : count_reg;

    always_comb begin
        n_pop = CW'(pop_count);
        if (n_pop > avail)
            n_pop = avail;
        if (n_pop > CW'(ISSUE_WIDTH))
            n_pop = CW'(ISSUE_WIDTH);
        if (stall)
            n_pop = '0;
    end

    assign wr_skip = bypass ? n_pop : '0;

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            lane_wr[i]   = push_ok && in_valid[i] && (lane_idx[i] >= wr_skip);
            lane_addr[i] = tail_reg + AW'(lane_idx[i] - wr_skip);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (lane_wr[i])
                mem[lane_addr[i]] <= lane_entry[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + AW'(bypass ? '0 : n_pop);
            tail_reg  <= tail_reg + AW'(n_push - wr_skip);
            count_reg <= count_reg + n_push - n_pop;
        end
    end

    assign count = count_reg;

`ifdef INSTBUFFER_BYPASS_EN
    logic [EW-1:0] comp_entry [ISSUE_WIDTH];

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            comp_entry[k] = '0;
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (in_valid[i] && (lane_idx[i] == CW'(k)))
                    comp_entry[k] = lane_entry[i];
            end
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_entry[k]  = '0;
            out_valid[k] = 1'b0;
`ifdef INSTBUFFER_BYPASS_EN
            if (bypass) begin
                if (CW'(k) < n_push) begin
                    out_valid[k] = 1'b1;
                    rd_entry[k]  = comp_entry[k];
                end
            end else
`endif
            if (CW'(k) < count_reg) begin
                out_valid[k] = 1'b1;
                rd_entry[k]  = mem[head_reg + AW'(k)];
            end
        end
    end

    generate
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_out
            assign out_pc[gi*32 +: 32]              = rd_entry[gi][110:79];
            assign out_inst[gi*32 +: 32]            = rd_entry[gi][78:47];
            assign out_is_branch[gi]                = rd_entry[gi][46];
            assign out_pre_taken[gi]                = rd_entry[gi][45];
            assign out_pre_branch_addr[gi*32 +: 32] = rd_entry[gi][44:13];
            assign out_is_exception[gi*6 +: 6]      = rd_entry[gi][12:7];
            assign out_exception_cause[gi*7 +: 7]   = rd_entry[gi][6:0];
        end
    endgenerate

endmodule
